// File: rtl/stepper_pkg.sv
// stepper_pkg: shared mode/direction encodings and the coil pattern function for the stepper sequencer
package stepper_pkg;
   typedef enum logic [1:0] {MODE_WAVE = 2'b00, MODE_FULL = 2'b01, MODE_HALF = 2'b10} mode_t;
   localparam logic DIR_CW = 1'b1;
   localparam logic DIR_CCW = 1'b0;
   localparam int MAX_PHASES = 32;
   function automatic logic [MAX_PHASES-1:0] coil_pattern(input int idx, input int phases);
      logic [MAX_PHASES-1:0] p;
      for (int k = 0; k < MAX_PHASES; k++)
         p[k] = k == idx / 2 || (idx % 2 == 1 && k == (idx + 1) / 2 % phases);
      return p;
   endfunction
endpackage

// File: rtl/stepper_phase_lut.sv
// stepper_phase_lut: combinational sequence index to coil pattern mapping
module stepper_phase_lut import stepper_pkg::*; #(
   parameter int PHASES = 4
) (
   input  logic [$clog2(2*PHASES)-1:0] idx,
   output logic [PHASES-1:0]           pat
);
   assign pat = PHASES'(coil_pattern(int'(idx), PHASES));
endmodule

// File: rtl/stepper_phase_sequencer.sv
// stepper_phase_sequencer: wave/full/half stepper sequencer with handshake, rate limit and position counter
// Optional idle de-energise timeout enabled by defining STEPPER_IDLE_OFF_EN.
module stepper_phase_sequencer import stepper_pkg::*; #(
   parameter int PHASES = 4,
   parameter int POS_W = 32,
   parameter int MIN_INTERVAL = 16,
   parameter int IDLE_CYCLES = 1000000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          step_req,
   input  logic                          dir,
   input  logic [1:0]                    mode,
   input  logic                          pos_clr,
   output logic [PHASES-1:0]             coil_out,
   output logic                          step_ack,
   output logic                          step_drop,
   output logic                          busy,
   output logic [POS_W-1:0]              position,
   output logic [$clog2(2*PHASES)-1:0]   phase_idx,
   output logic                          idle
);
   localparam int IW = $clog2(2*PHASES);
   localparam logic [IW:0] NV = (IW+1)'(2*PHASES);
   localparam int CW = MIN_INTERVAL > 1 ? $clog2(MIN_INTERVAL) : 1;
   localparam logic [CW-1:0] LD = CW'(MIN_INTERVAL > 1 ? MIN_INTERVAL - 1 : 0);

   logic [CW-1:0] cnt;
   logic accept, idle_n;
   logic [1:0] mag;
   logic [IW:0] up, dn;
   logic [IW-1:0] idx_n;
   logic [POS_W-1:0] delta, pos_n;
   logic [PHASES-1:0] pat;

   assign busy = cnt != '0;

   // wave realigns odd indices and full realigns even ones by a single step
   always_comb begin
      accept = step_req && en && !busy;
      mag = mode == MODE_WAVE ? (phase_idx[0] ? 2'd1 : 2'd2) :
            mode == MODE_FULL ? (phase_idx[0] ? 2'd2 : 2'd1) : 2'd1;
      up = {1'b0, phase_idx} + (IW+1)'(mag);
      dn = {1'b0, phase_idx} - (IW+1)'(mag);
      idx_n = !accept ? phase_idx :
              dir == DIR_CW ? IW'(up >= NV ? up - NV : up) : IW'(dn[IW] ? dn + NV : dn);
      delta = dir == DIR_CW ? POS_W'(mag) : -POS_W'(mag);
      pos_n = accept ? (pos_clr ? delta : position + delta) : (pos_clr ? '0 : position);
   end

   stepper_phase_lut #(.PHASES(PHASES)) u_lut (.idx(idx_n), .pat(pat));

`ifdef STEPPER_IDLE_OFF_EN
   localparam int DW = $clog2(IDLE_CYCLES + 1);
   logic [DW-1:0] ic, ic_n;
   assign ic_n = (!en || accept) ? '0 : ic == DW'(IDLE_CYCLES) ? ic : ic + DW'(1);
   assign idle_n = ic_n == DW'(IDLE_CYCLES);
   always_ff @(posedge clk)
      if (rst) ic <= '0;
      else ic <= ic_n;
`else
   assign idle_n = IDLE_CYCLES < 0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_idx <= '0;
         position <= '0;
         coil_out <= '0;
         step_ack <= 1'b0;
         step_drop <= 1'b0;
         cnt <= '0;
         idle <= 1'b0;
      end else begin
         phase_idx <= idx_n;
         position <= pos_n;
         coil_out <= en && !idle_n ? pat : '0;
         step_ack <= accept;
         step_drop <= step_req && !accept;
         cnt <= accept ? LD : busy ? cnt - CW'(1) : cnt;
         idle <= idle_n;
      end
   end
endmodule

// File: tb/tb_stepper_phase_sequencer.sv
// tb_stepper_phase_sequencer: directed self-checking bench for stepper_phase_sequencer
module tb_stepper_phase_sequencer;
   logic clk = 1'b0, rst = 1'b1, en = 1'b0, step_req = 1'b0, dir = 1'b1, pos_clr = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [3:0] coil_out;
   logic step_ack, step_drop, busy, idle;
   logic [31:0] position;
   logic [2:0] phase_idx;
   int total = 0, bad = 0;

   stepper_phase_sequencer #(.PHASES(4), .POS_W(32), .MIN_INTERVAL(16), .IDLE_CYCLES(100)) dut (
      .clk(clk), .rst(rst), .en(en), .step_req(step_req), .dir(dir), .mode(mode), .pos_clr(pos_clr),
      .coil_out(coil_out), .step_ack(step_ack), .step_drop(step_drop), .busy(busy),
      .position(position), .phase_idx(phase_idx), .idle(idle)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse();
      step_req = 1'b1;
      cyc(1);
      step_req = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      en = 1'b1;
      step_req = 1'b1;
      rst = 1'b1;
      cyc(3);
      step_req = 1'b0;
      total++; if (phase_idx !== 3'd0) begin bad++; $display("FAIL reset_idx got %0d want 0", phase_idx); end
      total++; if (position !== 32'd0) begin bad++; $display("FAIL reset_pos got %0d want 0", position); end
      total++; if (coil_out !== 4'b0000) begin bad++; $display("FAIL reset_coil got %b want 0000", coil_out); end
      total++; if ({step_ack, step_drop, busy, idle} !== 4'b0000) begin bad++; $display("FAIL reset_flags got %b want 0000", {step_ack, step_drop, busy, idle}); end
      rst = 1'b0;
   endtask

   task automatic test_full_cw();
      int e_idx[5] = '{1, 3, 5, 7, 1};
      logic [3:0] e_coil[5] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001, 4'b0011};
      int e_pos[5] = '{1, 3, 5, 7, 9};
      do_reset();
      mode = 2'b01;
      dir = 1'b1;
      en = 1'b1;
      cyc(2);
      for (int i = 0; i < 5; i++) begin
         pulse();
         total++; if (phase_idx !== 3'(e_idx[i])) begin bad++; $display("FAIL full_idx%0d got %0d want %0d", i, phase_idx, e_idx[i]); end
         total++; if (coil_out !== e_coil[i]) begin bad++; $display("FAIL full_coil%0d got %b want %b", i, coil_out, e_coil[i]); end
         total++; if (position !== 32'(e_pos[i])) begin bad++; $display("FAIL full_pos%0d got %0d want %0d", i, position, e_pos[i]); end
         total++; if (step_ack !== 1'b1) begin bad++; $display("FAIL full_ack%0d got %b want 1", i, step_ack); end
         cyc(1);
         total++; if (step_ack !== 1'b0) begin bad++; $display("FAIL full_ack_end%0d got %b want 0", i, step_ack); end
         cyc(18);
      end
   endtask

   task automatic test_half_ccw();
      do_reset();
      mode = 2'b10;
      dir = 1'b0;
      en = 1'b1;
      cyc(1);
      pulse();
      total++; if ({phase_idx, coil_out} !== {3'd7, 4'b1001}) begin bad++; $display("FAIL half1 got idx=%0d coil=%b want idx=7 coil=1001", phase_idx, coil_out); end
      total++; if (position !== 32'hFFFF_FFFF) begin bad++; $display("FAIL half1_pos got %h want ffffffff", position); end
      cyc(19);
      pulse();
      total++; if ({phase_idx, coil_out} !== {3'd6, 4'b1000}) begin bad++; $display("FAIL half2 got idx=%0d coil=%b want idx=6 coil=1000", phase_idx, coil_out); end
      total++; if (position !== 32'hFFFF_FFFE) begin bad++; $display("FAIL half2_pos got %h want fffffffe", position); end
   endtask

   task automatic test_rate_limit();
      do_reset();
      mode = 2'b10;
      dir = 1'b1;
      en = 1'b1;
      cyc(1);
      pulse();
      total++; if ({step_ack, position} !== {1'b1, 32'd1}) begin bad++; $display("FAIL rate_first got ack=%b pos=%0d want ack=1 pos=1", step_ack, position); end
      for (int c = 1; c < 10; c++) begin
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL rate_busy_c%0d got %b want 1", c, busy); end
         cyc(1);
      end
      pulse();
      total++; if ({step_drop, step_ack, position} !== {1'b1, 1'b0, 32'd1}) begin bad++; $display("FAIL rate_drop got drop=%b ack=%b pos=%0d want drop=1 ack=0 pos=1", step_drop, step_ack, position); end
      for (int c = 11; c < 16; c++) begin
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL rate_busy_c%0d got %b want 1", c, busy); end
         cyc(1);
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rate_busy_c16 got %b want 0", busy); end
      pulse();
      total++; if ({step_ack, step_drop, position} !== {1'b1, 1'b0, 32'd2}) begin bad++; $display("FAIL rate_second got ack=%b drop=%b pos=%0d want ack=1 drop=0 pos=2", step_ack, step_drop, position); end
   endtask

   task automatic test_enable();
      do_reset();
      mode = 2'b01;
      dir = 1'b1;
      en = 1'b1;
      cyc(1);
      pulse();
      cyc(19);
      pulse();
      cyc(19);
      en = 1'b0;
      cyc(1);
      total++; if ({coil_out, phase_idx} !== {4'b0000, 3'd3}) begin bad++; $display("FAIL en_off got coil=%b idx=%0d want coil=0000 idx=3", coil_out, phase_idx); end
      pulse();
      total++; if ({step_drop, step_ack, phase_idx} !== {1'b1, 1'b0, 3'd3}) begin bad++; $display("FAIL en_off_req got drop=%b ack=%b idx=%0d want drop=1 ack=0 idx=3", step_drop, step_ack, phase_idx); end
      cyc(3);
      en = 1'b1;
      cyc(1);
      total++; if ({coil_out, phase_idx, position} !== {4'b0110, 3'd3, 32'd3}) begin bad++; $display("FAIL en_on got coil=%b idx=%0d pos=%0d want coil=0110 idx=3 pos=3", coil_out, phase_idx, position); end
   endtask

   task automatic test_pos_clr();
      do_reset();
      mode = 2'b00;
      dir = 1'b1;
      en = 1'b1;
      cyc(1);
      for (int i = 0; i < 21; i++) begin
         pulse();
         cyc(16);
      end
      total++; if ({position, phase_idx} !== {32'd42, 3'd2}) begin bad++; $display("FAIL wave_run got pos=%0d idx=%0d want pos=42 idx=2", position, phase_idx); end
      mode = 2'b10;
      pos_clr = 1'b1;
      pulse();
      pos_clr = 1'b0;
      total++; if ({position, phase_idx} !== {32'd1, 3'd3}) begin bad++; $display("FAIL pos_clr got pos=%0d idx=%0d want pos=1 idx=3", position, phase_idx); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      mode = 2'b10;
      dir = 1'b1;
      en = 1'b1;
      cyc(1);
      for (int i = 0; i < 5; i++) begin
         pulse();
         if (i < 4) cyc(16);
      end
      cyc(4);
      total++; if ({busy, phase_idx} !== {1'b1, 3'd5}) begin bad++; $display("FAIL mid_pre got busy=%b idx=%0d want busy=1 idx=5", busy, phase_idx); end
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      total++; if ({busy, phase_idx, position, coil_out} !== {1'b0, 3'd0, 32'd0, 4'b0000}) begin bad++; $display("FAIL mid_rst got busy=%b idx=%0d pos=%0d coil=%b want 0 0 0 0000", busy, phase_idx, position, coil_out); end
   endtask

   task automatic test_idle();
      do_reset();
      mode = 2'b10;
      dir = 1'b1;
      en = 1'b1;
      cyc(1);
      pulse();
      cyc(120);
`ifdef STEPPER_IDLE_OFF_EN
      total++; if ({idle, coil_out, phase_idx} !== {1'b1, 4'b0000, 3'd1}) begin bad++; $display("FAIL idle_on got idle=%b coil=%b idx=%0d want 1 0000 1", idle, coil_out, phase_idx); end
      pulse();
      total++; if ({idle, coil_out, phase_idx} !== {1'b0, 4'b0010, 3'd2}) begin bad++; $display("FAIL idle_wake got idle=%b coil=%b idx=%0d want 0 0010 2", idle, coil_out, phase_idx); end
`else
      total++; if ({idle, coil_out, phase_idx} !== {1'b0, 4'b0011, 3'd1}) begin bad++; $display("FAIL idle_off got idle=%b coil=%b idx=%0d want 0 0011 1", idle, coil_out, phase_idx); end
`endif
   endtask

   initial begin
      test_reset();
      test_full_cw();
      test_half_ccw();
      test_rate_limit();
      test_enable();
      test_pos_clr();
      test_reset_mid();
      test_idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
